// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and helpers for the fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Occupancy counters must represent every value from 0 to depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO of fetch entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = cnt_width(DEPTH),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_wdata,
    output fetch_entry_t  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];
    assign o_count   = r_count;

    // Pointer and occupancy tracking; flush overrides any push or pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the top gates every read with o_empty
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - RV32I fetch stage with prefetch FIFO, optional FETCH_BYPASS_EN
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectPc,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic            imemRvalid,
    input  logic [XLEN-1:0] imemRdata,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4
);
    localparam int CW = cnt_width(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_live;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wdata;
    logic            w_push;
    logic            w_pop;
    logic            w_accept;
    logic            w_resp_drop;
    logic            w_resp_keep;
    logic [CW:0]     w_inflight;
    logic [CW:0]     w_outstanding;
    logic [XLEN-1:0] w_target;
    logic            w_unused_bits;

    assign w_inflight    = {1'b0, r_live} + {1'b0, r_drop};
    assign w_outstanding = w_inflight + {1'b0, w_count};
    // Reset gating keeps the bus quiet while the memory side is also held in reset
    assign imemReq       = reset && !redirect && (w_outstanding < (CW+1)'(DEPTH));
    assign imemAddr      = r_fetch_pc;
    assign w_accept      = imemReq && imemReady;
    assign w_resp_drop   = imemRvalid && (r_drop != '0);
    assign w_resp_keep   = imemRvalid && (r_drop == '0) && !redirect;
    assign w_target      = {redirectPc[XLEN-1:2], 2'b00};
    assign w_unused_bits = &{1'b0, redirectPc[1:0]};
    assign w_wdata       = '{instr: imemRdata, pc: r_resp_pc};

`ifdef FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_empty && w_resp_keep;
    assign w_push   = w_resp_keep && !(w_bypass && !stall);
    assign w_pop    = !w_empty && !stall;
`else
    assign w_push   = w_resp_keep;
    assign w_pop    = !w_empty && !stall;
`endif

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Present the FIFO head (or a same-cycle bypassed response); zeros when nothing is valid
    always_comb begin
        valid   = 1'b0;
        instr   = '0;
        pc      = '0;
        pcPlus4 = '0;
`ifdef FETCH_BYPASS_EN
        if (w_bypass) begin
            valid   = 1'b1;
            instr   = imemRdata;
            pc      = r_resp_pc;
            pcPlus4 = r_resp_pc + 32'd4;
        end else if (!w_empty) begin
            valid   = 1'b1;
            instr   = w_head.instr;
            pc      = w_head.pc;
            pcPlus4 = w_head.pc + 32'd4;
        end
`else
        if (!w_empty) begin
            valid   = 1'b1;
            instr   = w_head.instr;
            pc      = w_head.pc;
            pcPlus4 = w_head.pc + 32'd4;
        end
`endif
    end

    // Fetch/response PCs and in-flight bookkeeping; a redirect turns all live requests into drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_live     <= '0;
            r_drop     <= '0;
        end else if (redirect) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            r_live     <= '0;
            r_drop     <= CW'(w_inflight - (CW+1)'(imemRvalid));
        end else begin
            if (w_accept)    r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_resp_keep) r_resp_pc  <= r_resp_pc + 32'd4;
            r_live <= r_live + CW'(w_accept) - CW'(w_resp_keep);
            if (w_resp_drop) r_drop <= r_drop - 1'b1;
        end
    end

    // Protocol checks: no orphan responses, and the capacity rule must keep the FIFO from overflowing
    always_ff @(posedge clk or negedge reset) begin
        if (reset) begin
            assert (!(imemRvalid && (w_inflight == '0)));
            assert (!(w_push && w_full));
        end
    end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction fetch stage of the RV32I pipeline.
- Owns the fetch PC and issues in-order requests to instruction memory, which has variable latency.
- Buffers returned instructions in a small prefetch FIFO.
- Presents instr/pc/pcPlus4 plus a valid flag to the Fetch/Decode stage register.
- Handles Decode stall and Execute redirect (branch/jump), including discard of stale in-flight responses.

Parameters:
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests (power of 2, >= 2)
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- stall  input  1  Decode cannot accept; hold head entry
- redirect  input  1  taken branch/jump from Execute
- redirectPc  input  32  new fetch target
- imemReq  output  1  request valid
- imemAddr  output  32  request word address
- imemReady  input  1  memory accepts request this cycle
- imemRvalid  input  1  response valid (in request order)
- imemRdata  input  32  response instruction word
- valid  output  1  instr/pc/pcPlus4 hold a real instruction
- instr  output  32  instruction to Fetch/Decode register
- pc  output  32  its address
- pcPlus4  output  32  pc + 4, mod 2^32

Behaviour:
- Reset (async assert, sync release):
  - fetchPc=RESET_PC, respPc=RESET_PC.
  - FIFO empty; liveCnt=0, dropCnt=0.
  - valid=0, instr=0, pc=0, pcPlus4=0, imemReq=0.
  - Reset mid-transaction forgets all in-flight requests; the memory model is reset with the block.
- Outputs: combinational from FIFO head. When empty: valid=0, instr/pc/pcPlus4=0.
- Pop: when valid && !stall. A stall holds the head unchanged indefinitely.
- Request issue:
  - imemReq = !redirect && (count + liveCnt + dropCnt) < DEPTH.
  - imemAddr = fetchPc.
  - Accept = imemReq && imemReady. On accept: fetchPc += 4, liveCnt++.
  - imemReq may drop while unaccepted (no hold requirement on this simple bus).
- Response (imemRvalid):
  - If dropCnt>0: discard, dropCnt--.
  - Else: push {imemRdata, respPc}, respPc += 4, liveCnt--.
  - The capacity rule guarantees the FIFO never overflows. Push to a full FIFO is an assertion failure.
  - Response with liveCnt+dropCnt==0 is a protocol error (assertion).
- Redirect (priority over everything in its cycle):
  - FIFO flushed. No pop is credited to Decode; the Decode/Execute side handles its own flush.
  - fetchPc and respPc <= {redirectPc[31:2],2'b00}.
  - dropCnt <= liveCnt + dropCnt - (imemRvalid ? 1 : 0); liveCnt <= 0.
  - No request issued that cycle; any response that cycle is discarded.
  - Redirect and stall together: the flush wins; valid=0 next cycle.
  - Back-to-back redirects accumulate correctly in dropCnt.
- Latency: a response is visible on outputs the cycle after imemRvalid (registered FIFO), unless FETCH_BYPASS_EN.
- Arithmetic: 32-bit wrap; 32'hFFFF_FFFC + 4 = 0.
- Counters are $clog2(DEPTH)+1 bits wide; they never exceed DEPTH.

Optional Feature:
- FETCH_BYPASS_EN:
  - Defined: when the FIFO is empty, imemRvalid is not dropped and redirect=0, the response drives valid/instr/pc/pcPlus4 combinationally that same cycle.
  - If also !stall, it is consumed without being written to the FIFO; otherwise it is pushed as normal.
- Undefined: every response goes through the FIFO; minimum one-cycle response-to-output latency.

Decomposition:
- Package fetch_pkg:
  - XLEN=32, NOP=32'h0000_0013.
  - typedef struct fetch_entry_t {instr[31:0], pc[31:0]}.
  - Counter width function.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH entries, push/pop/flush, count, full/empty.
  - Flush has priority over push/pop.
  - Simultaneous push and pop when non-empty keeps count.

Test Plan:
- Reset release, memory with 1-cycle latency, no stall -> imemAddr 0,4,8,...; valid from 2nd response cycle; pc 0,4,8 with pcPlus4 4,8,12.
- stall held 10 cycles, DEPTH=4 -> exactly 4 requests accepted, imemReq=0 afterwards, head stays pc=0; stall release drains 0,4,8,12 on consecutive cycles.
- Memory latency 3, redirect to 32'h100 with 2 requests live -> the next 2 responses are discarded; first valid output has pc=0x100 and instr equal to the word at 0x100.
- Redirect in the same cycle as imemRvalid and stall=1 -> response dropped, FIFO empty next cycle, dropCnt = previous liveCnt-1, fetch resumes at target.
- redirectPc=32'h0000_0102 -> fetch at 0x100. Fetch from 0xFFFF_FFFC -> pcPlus4=0, next request addr 0.
- Reset asserted mid-burst with 2 outstanding -> all outputs 0 immediately (async); after release, fetch restarts at RESET_PC with no stale instruction delivered.
